// File: rtl/vga_timing_ctrl_if.sv
// Display-side bundle produced by the VGA timing controller.
// The timing generator drives it through the master modport and the renderer
// or RGB gate reads it through the slave modport.
// Optional feature macro: VGA_FRAME_TICK_EN adds the frame_tick pulse.
interface vga_timing_ctrl_if;
    logic [9:0] px;
    logic [9:0] py;
    logic       active;
    logic       hsync;
    logic       vsync;
`ifdef VGA_FRAME_TICK_EN
    logic       frame_tick;

    modport master (output px, output py, output active, output hsync, output vsync, output frame_tick);
    modport slave  (input  px, input  py, input  active, input  hsync, input  vsync, input  frame_tick);
`else
    modport master (output px, output py, output active, output hsync, output vsync);
    modport slave  (input  px, input  py, input  active, input  hsync, input  vsync);
`endif
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller.
// Horizontal and vertical counters advance on pix_ce. Four-phase FSMs
// (ACTIVE, FP, SYNC, BP) track where each counter is in its line or frame.
// px/py are registered directly from the counters.
// active/hsync/vsync are registered once and then delayed RENDER_LAT more
// pixel ticks, so they line up with a renderer of that pipeline depth.
// Optional feature macro: VGA_FRAME_TICK_EN adds frame_tick, a one-clock
// pulse on the pix_ce tick that issues pixel (0,0).
module vga_timing_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int RENDER_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_ce,
    vga_timing_ctrl_if.master         vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count value of each phase; a phase ends on the tick where the
    // counter sits on its last value.
    localparam logic [9:0] H_END_ACT  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_END_FP   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_END_SYNC = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END_ACT  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_END_FP   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_END_SYNC = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    // Pipeline word layout: {de, hsync, vsync}. The idle word is shown while
    // the pipeline refills after reset.
    localparam logic [2:0] IDLE_WORD = {1'b0, ~SYNC_POL, ~SYNC_POL};

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    phase_e     h_phase_q, h_phase_d;
    phase_e     v_phase_q, v_phase_d;
    logic [9:0] px_q, px_d;
    logic [9:0] py_q, py_d;
    logic [2:0] pipe_q [RENDER_LAT+1];
    logic [2:0] pipe_d [RENDER_LAT+1];

    logic       line_end;
    logic       raw_de;
    logic       raw_hs;
    logic       raw_vs;

    assign line_end = (hc_q == H_LAST);

    // Raw timing is decoded from the phase FSMs, which track the current counters.
    always_comb begin
        raw_de = (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
        raw_hs = (h_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        raw_vs = (v_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    // Counter next state: hc wraps at the end of the line and carries into vc.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_ce) begin
            if (line_end) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Horizontal phase FSM next state: step to the next phase after the last pixel of the current one.
    always_comb begin
        h_phase_d = h_phase_q;
        if (pix_ce) begin
            unique case (h_phase_q)
                PH_ACTIVE: if (hc_q == H_END_ACT)  h_phase_d = PH_FP;
                PH_FP:     if (hc_q == H_END_FP)   h_phase_d = PH_SYNC;
                PH_SYNC:   if (hc_q == H_END_SYNC) h_phase_d = PH_BP;
                PH_BP:     if (hc_q == H_LAST)     h_phase_d = PH_ACTIVE;
                default:                           h_phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Vertical phase FSM next state: moves only on the tick that ends a line.
    always_comb begin
        v_phase_d = v_phase_q;
        if (pix_ce && line_end) begin
            unique case (v_phase_q)
                PH_ACTIVE: if (vc_q == V_END_ACT)  v_phase_d = PH_FP;
                PH_FP:     if (vc_q == V_END_FP)   v_phase_d = PH_SYNC;
                PH_SYNC:   if (vc_q == V_END_SYNC) v_phase_d = PH_BP;
                PH_BP:     if (vc_q == V_LAST)     v_phase_d = PH_ACTIVE;
                default:                           v_phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Coordinates and the alignment pipeline: stage 0 samples the raw timing and each later stage shifts one tick.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        for (int i = 0; i <= RENDER_LAT; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (pix_ce) begin
            px_d      = raw_de ? hc_q : '0;
            py_d      = raw_de ? vc_q : '0;
            pipe_d[0] = {raw_de, raw_hs, raw_vs};
            for (int i = 1; i <= RENDER_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // State registers. Reset takes priority over pix_ce and restarts at pixel (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q      <= '0;
            vc_q      <= '0;
            h_phase_q <= PH_ACTIVE;
            v_phase_q <= PH_ACTIVE;
            px_q      <= '0;
            py_q      <= '0;
            for (int i = 0; i <= RENDER_LAT; i++) begin
                pipe_q[i] <= IDLE_WORD;
            end
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            h_phase_q <= h_phase_d;
            v_phase_q <= v_phase_d;
            px_q      <= px_d;
            py_q      <= py_d;
            for (int i = 0; i <= RENDER_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign vif.px     = px_q;
    assign vif.py     = py_q;
    assign vif.active = pipe_q[RENDER_LAT][2];
    assign vif.hsync  = pipe_q[RENDER_LAT][1];
    assign vif.vsync  = pipe_q[RENDER_LAT][0];

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // Frame pulse: set on the tick that issues pixel (0,0), so it lasts one clock.
    always_comb begin
        frame_tick_d = pix_ce && (hc_q == '0) && (vc_q == '0);
    end

    // Frame pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vif.frame_tick = frame_tick_q;
`endif

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP, 10; V_SYNC, 2; V_BP, 33: vertical front porch, sync and back porch widths in lines.
REQ-005 Parameter SYNC_POL, 0, sync asserted level (0 = active-low).
REQ-006 Parameter RENDER_LAT, 2, renderer pipeline depth in pixel ticks (0..7).
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 pix_ce  input  1  pixel-rate enable; all counters and the alignment pipeline advance only on cycles with pix_ce=1.
REQ-010 px  output  10  current pixel column to renderer (undelayed).
REQ-011 py  output  10  current pixel row to renderer (undelayed).
REQ-012 active  output  1  display enable, delayed RENDER_LAT ticks; drives the RGB gate enable.
REQ-013 hsync  output  1  horizontal sync, delayed RENDER_LAT ticks.
REQ-014 vsync  output  1  vertical sync, delayed RENDER_LAT ticks.
REQ-015 frame_tick  output  1  one-clock pulse at frame start (present only with VGA_FRAME_TICK_EN).

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-017 Horizontal counter hc counts 0..H_TOTAL-1 on each pix_ce, wrapping to 0; it holds when pix_ce=0.
REQ-018 Vertical counter vc increments on the pix_ce where hc wraps, counts 0..V_TOTAL-1, and wraps to 0 at the last pixel of line V_TOTAL-1.
REQ-019 Horizontal phase FSM: ACTIVE (hc<H_ACTIVE) -> FP -> SYNC -> BP -> ACTIVE; vertical FSM uses the same four phases on vc.
REQ-020 Raw DE = (hc<H_ACTIVE) and (vc<V_ACTIVE).
REQ-021 Raw hsync asserted (=SYNC_POL) for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
REQ-022 Raw vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
REQ-023 px = hc and py = vc during raw DE; px and py hold 0 outside raw DE.
REQ-024 active, hsync, vsync are raw signals passed through a RENDER_LAT-stage shift register clocked on pix_ce; RENDER_LAT=0 means raw signals are registered once with no extra delay.
REQ-025 All outputs are registered; no combinational path from pix_ce to any output.
REQ-026 Coordinate-to-active alignment: pixel (x,y) issued on px/py at tick t appears with active=1 at tick t+RENDER_LAT.
REQ-027 pix_ce held low for any duration freezes all state; resumption continues without skipped or repeated pixels.

Reset
REQ-028 On rst=1 at a clk edge, hc=0, vc=0, px=0, py=0, active=0, hsync=vsync=~SYNC_POL, all pipeline stages loaded with inactive values, frame_tick=0.
REQ-029 rst has priority over pix_ce; reset mid-frame restarts timing at pixel (0,0) on the first pix_ce after release.

Configuration
REQ-030 Macro VGA_FRAME_TICK_EN defined: frame_tick port exists and pulses high for exactly one clk cycle on the pix_ce where hc=0 and vc=0 (undelayed), including the first tick after reset.
REQ-031 VGA_FRAME_TICK_EN undefined: frame_tick port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-032 Reset, pix_ce=1 every cycle, RENDER_LAT=2 -> hsync low for exactly 96 ticks starting 2 ticks after hc=656; line period 800 ticks.
REQ-033 Run one full frame -> vsync low for exactly 2 lines (1600 ticks) starting 2 ticks after vc=490; frame period 420000 ticks; 307200 ticks with active=1.
REQ-034 pix_ce=1 every 4th cycle -> same tick counts as REQ-032/033 measured in pix_ce ticks; outputs stable between ticks.
REQ-035 Assert rst at hc=300, vc=200 for one cycle -> next pix_ce produces px=0, py=0; active=0, hsync=vsync=1 during reset.
REQ-036 VGA_FRAME_TICK_EN defined -> frame_tick one clk wide every 420000 ticks, first on the first pix_ce after reset; undefined -> build without the port passes lint.
REQ-037 Drive px/py into a latency-2 renderer model and gate output by active -> first gated nonzero pixel corresponds to (0,0); no pixel of column 639 lost or column 640 shown.
